// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared definitions for serial arithmetic controllers:
//               FSM state encoding and the bit-counter width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  // Serial controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter width able to index bits 0..w-1; never narrower than 1 bit.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder1bit.sv
`default_nettype none
// ============================================================================
// Module      : adder1bit
// Description : Single-bit full adder.
// Ports       : a, b  - addend bits
//               ci    - carry in
//               sum   - a ^ b ^ ci
//               c     - carry out
// Revision    : 1.0 - initial release
// ============================================================================
module adder1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic c
);

  logic w_p;

  assign w_p = a ^ b;
  assign sum = w_p ^ ci;
  assign c   = (a & b) | (ci & w_p);

endmodule : adder1bit
`default_nettype wire

// File: rtl/bit_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_add_ctrl
// Description : Bit-serial WIDTH-bit adder. Operands are captured on a
//               valid/ready handshake, added LSB first one bit per clock
//               through a single full adder, and the result is held with a
//               valid/ready handshake until consumed.
// Ports       : clk, rst              - clock, async active-high reset
//               in_valid / in_ready   - operand handshake
//               a_in, b_in, cin       - operands and carry in
//               busy                  - serial addition in progress
//               out_valid / out_ready - result handshake
//               sum_out, cout         - {cout,sum_out} = a_in + b_in + cin
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int             CNT_W  = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_s_sr;
  logic [WIDTH-1:0]   w_s_next;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_sum;
  logic               w_c;
  logic               w_last;

  // Datapath: one full adder fed from the operand LSBs and the carry flop.
  adder1bit u_fa (
    .a   (r_a_sr[0]),
    .b   (r_b_sr[0]),
    .ci  (r_carry),
    .sum (w_sum),
    .c   (w_c)
  );

  // Result shifts in from the MSB end so bit 0 lands in place after WIDTH steps.
  generate
    if (WIDTH == 1) begin : g_s_w1
      assign w_s_next = w_sum;
    end else begin : g_s_wn
      assign w_s_next = {w_sum, r_s_sr[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sr  <= a_in;
            r_b_sr  <= b_in;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_s_sr  <= w_s_next;
          r_carry <= w_c;
          // Park at zero on the final bit so the counter never passes WIDTH-1.
          r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    sum_out   = '0;
    cout      = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Gated by rst so the block never advertises ready while held in reset.
        in_ready = ~rst;
        if (in_valid && !rst) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        sum_out   = r_s_sr;
        cout      = r_carry;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule : bit_serial_add_ctrl
`default_nettype wire

// File: tb/tb_bit_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serial_add_ctrl
// Description : Self-checking bench for bit_serial_add_ctrl with a WIDTH=8
//               and a WIDTH=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8 instance signals
  logic       iv8 = 0, ir8, busy8, ov8, or8 = 0, cin8 = 0, cout8;
  logic [7:0] a8 = 0, b8 = 0, s8;

  // WIDTH=1 instance signals
  logic       iv1 = 0, ir1, busy1, ov1, or1 = 0, cin1 = 0, cout1;
  logic [0:0] a1 = 0, b1 = 0, s1;

  bit_serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a_in(a8), .b_in(b8),
    .cin(cin8), .busy(busy8), .out_valid(ov8), .out_ready(or8), .sum_out(s8), .cout(cout8)
  );

  bit_serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a_in(a1), .b_in(b1),
    .cin(cin1), .busy(busy1), .out_valid(ov1), .out_ready(or1), .sum_out(s1), .cout(cout1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  // Runs one WIDTH=8 op; returns result, latency (edges) and busy-cycle count.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     output logic [7:0] s, output logic co, output int lat, output int bc);
    int n;
    n = 0;
    while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
    check("op8_in_ready_timeout", {31'd0, ir8}, 32'd1);
    a8 = a; b8 = b; cin8 = c; iv8 = 1;
    @(posedge clk); #1;
    iv8 = 0; a8 = 8'h00; b8 = 8'h00; cin8 = 0;
    bc = busy8 ? 1 : 0;
    check("op8_sum_zero_in_run", {23'd0, cout8, s8}, 32'd0);
    lat = 0;
    while (!ov8 && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (busy8) bc++;
    end
    s = s8; co = cout8;
  endtask

  task automatic handshake8();
    or8 = 1;
    @(posedge clk); #1;
    or8 = 0;
    check("hs_out_valid_drops", {31'd0, ov8}, 32'd0);
    check("hs_in_ready_back", {31'd0, ir8}, 32'd1);
    check("hs_result_not_held", {23'd0, cout8, s8}, 32'd0);
  endtask

  initial begin
    vec_t       vt[8];
    logic [1:0] w1_exp[8];
    logic [7:0] s;
    logic       co;
    int         lat, bc, n, prev_acc, acc;
    logic [7:0] ra, rb;
    logic       rc;

    vt[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vt[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vt[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vt[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    w1_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // Reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, ir8}, 32'd0);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_out_valid", {31'd0, ov8}, 32'd0);
    check("rst_sum_cout", {23'd0, cout8, s8}, 32'd0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'd0, ir8}, 32'd1);

    // Table-driven WIDTH=8 vectors
    foreach (vt[i]) begin
      op8(vt[i].a, vt[i].b, vt[i].cin, s, co, lat, bc);
      check($sformatf("vec%0d_sum", i), {24'd0, s}, {24'd0, vt[i].sum});
      check($sformatf("vec%0d_cout", i), {31'd0, co}, {31'd0, vt[i].cout});
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_busy_cycles", i), bc, 8);
      handshake8();
    end

    // Backpressure in DONE with new operands offered
    op8(8'h3C, 8'h5A, 1'b0, s, co, lat, bc);
    a8 = 8'hEE; b8 = 8'hEE; cin8 = 1; iv8 = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, ov8}, 32'd1);
      check("bp_sum", {24'd0, s8}, 32'h96);
      check("bp_cout", {31'd0, cout8}, 32'd0);
      check("bp_in_ready", {31'd0, ir8}, 32'd0);
    end
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    handshake8();
    op8(8'h10, 8'h20, 1'b0, s, co, lat, bc);
    check("bp_next_sum", {23'd0, co, s}, 32'h030);
    handshake8();

    // Asynchronous reset mid-RUN at cnt=3
    a8 = 8'h80; b8 = 8'h80; cin8 = 0; iv8 = 1;
    @(posedge clk); #1; iv8 = 0;
    repeat (3) @(posedge clk);
    #3 rst = 1;
    #1;
    check("arst_busy", {31'd0, busy8}, 32'd0);
    check("arst_out_valid", {31'd0, ov8}, 32'd0);
    check("arst_sum_cout", {23'd0, cout8, s8}, 32'd0);
    check("arst_in_ready", {31'd0, ir8}, 32'd0);
    @(negedge clk); rst = 0;
    #1;
    check("arst_release_in_ready", {31'd0, ir8}, 32'd1);
    op8(8'h01, 8'h01, 1'b0, s, co, lat, bc);
    check("arst_fresh_sum", {23'd0, co, s}, 32'h002);
    handshake8();

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      n = 0;
      while (!ir1 && n < 20) begin @(posedge clk); #1; n++; end
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; iv1 = 1;
      @(posedge clk); #1; iv1 = 0;
      lat = 0;
      while (!ov1 && lat < 20) begin @(posedge clk); #1; lat++; end
      check($sformatf("w1_%0d_result", i), {30'd0, cout1, s1}, {30'd0, w1_exp[i]});
      check($sformatf("w1_%0d_latency", i), lat, 1);
      or1 = 1; @(posedge clk); #1; or1 = 0;
    end

    // Random back-to-back ops with out_ready held high
    or8 = 1; iv8 = 1;
    prev_acc = -1;
    for (int it = 0; it < 1000; it++) begin
      n = 0;
      while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      a8 = ra; b8 = rb; cin8 = rc;
      @(posedge clk); #1;
      acc = cyc;
      if (prev_acc >= 0) check("rand_ii", acc - prev_acc, 10);
      prev_acc = acc;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      n = 0;
      while (!ov8 && n < 50) begin @(posedge clk); #1; n++; end
      check("rand_result", {23'd0, cout8, s8}, {23'd0, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}});
    end
    iv8 = 0; or8 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_bit_serial_add_ctrl
`default_nettype wire
